// File: rtl/mips_main_control.sv
// Main opcode decoder for a single-issue MIPS datapath.
// Control strobes are registered, giving one cycle of latency.
module mips_main_control #(
    parameter int OPW  = 6,
    parameter int AOPW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OPW-1:0]  opcode,
    input  logic            op_valid,
    output logic            RegDst,
    output logic            ALUSrc,
    output logic            MemtoReg,
    output logic            RegWrite,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            Branch,
    output logic [AOPW-1:0] ALUOp,
    output logic [9:0]      ctrl_word,
    output logic            illegal
);

    typedef struct packed {
        logic            regdst;
        logic            regwrite;
        logic [AOPW-1:0] aluop;
        logic            memwrite;
        logic            memread;
        logic            memtoreg;
        logic            branch;
        logic            alusrc;
    } ctrl_t;

    localparam logic [OPW-1:0] OP_R    = 6'b000000;
    localparam logic [OPW-1:0] OP_ADDI = 6'b001000;
    localparam logic [OPW-1:0] OP_ANDI = 6'b001100;
    localparam logic [OPW-1:0] OP_ORI  = 6'b001101;
    localparam logic [OPW-1:0] OP_SLTI = 6'b001010;
    localparam logic [OPW-1:0] OP_LW   = 6'b100011;
    localparam logic [OPW-1:0] OP_SW   = 6'b101011;
    localparam logic [OPW-1:0] OP_BEQ  = 6'b000100;

    logic  is_r, is_addi, is_andi, is_ori;
    logic  is_slti, is_lw, is_sw, is_beq;
    ctrl_t ctrl_d, ctrl_q;
    logic  ill_d, ill_q;

    assign is_r    = (opcode == OP_R);
    assign is_addi = (opcode == OP_ADDI);
    assign is_andi = (opcode == OP_ANDI);
    assign is_ori  = (opcode == OP_ORI);
    assign is_slti = (opcode == OP_SLTI);
    assign is_lw   = (opcode == OP_LW);
    assign is_sw   = (opcode == OP_SW);
    assign is_beq  = (opcode == OP_BEQ);

    // X/Z opcodes match no item and fall into the illegal default
    always_comb begin
        ctrl_d = '0;
        ill_d  = 1'b0;
        if (op_valid) begin
            unique case (1'b1)
                is_r:    ctrl_d = '{1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
                is_addi: ctrl_d = '{1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
                is_andi: ctrl_d = '{1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
                is_ori:  ctrl_d = '{1'b0, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
                is_slti: ctrl_d = '{1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
                is_lw:   ctrl_d = '{1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
                is_sw:   ctrl_d = '{1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
                is_beq:  ctrl_d = '{1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
                default: ill_d  = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
            ill_q  <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            ill_q  <= ill_d;
        end
    end

    assign RegDst    = ctrl_q.regdst;
    assign RegWrite  = ctrl_q.regwrite;
    assign ALUOp     = ctrl_q.aluop;
    assign MemWrite  = ctrl_q.memwrite;
    assign MemRead   = ctrl_q.memread;
    assign MemtoReg  = ctrl_q.memtoreg;
    assign Branch    = ctrl_q.branch;
    assign ALUSrc    = ctrl_q.alusrc;
    assign ctrl_word = ctrl_q;
    assign illegal   = ill_q;

endmodule

// File: tb/tb_mips_main_control.sv
// Scoreboard bench for mips_main_control.
// Expected decode is queued when driven and compared one edge later.
module tb_mips_main_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       op_valid;
    logic       RegDst, ALUSrc, MemtoReg, RegWrite;
    logic       MemRead, MemWrite, Branch, illegal;
    logic [2:0] ALUOp;
    logic [9:0] ctrl_word;

    int checks;
    int errors;

    logic [10:0] sb[$];

    mips_main_control #(.OPW(6), .AOPW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .op_valid  (op_valid),
        .RegDst    (RegDst),
        .ALUSrc    (ALUSrc),
        .MemtoReg  (MemtoReg),
        .RegWrite  (RegWrite),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Branch    (Branch),
        .ALUOp     (ALUOp),
        .ctrl_word (ctrl_word),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // {illegal, ctrl_word} straight from the decode table
    function automatic logic [10:0] model(input logic [5:0] op,
                                          input logic v);
        if (!v) return 11'b0;
        case (op)
            6'b000000: return {1'b0, 10'b1101000000};
            6'b001000: return {1'b0, 10'b0100000001};
            6'b001100: return {1'b0, 10'b0101100001};
            6'b001101: return {1'b0, 10'b0110000001};
            6'b001010: return {1'b0, 10'b0110100001};
            6'b100011: return {1'b0, 10'b0100001101};
            6'b101011: return {1'b0, 10'b0000010001};
            6'b000100: return {1'b0, 10'b0000100010};
            default:   return {1'b1, 10'b0};
        endcase
    endfunction

    task automatic step(input string tag, input logic [5:0] op,
                        input logic v);
        logic [10:0] exp;
        opcode   = op;
        op_valid = v;
        sb.push_back(model(op, v));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            exp = sb.pop_front();
            chk(tag, {21'b0, illegal, ctrl_word}, {21'b0, exp});
        end
    endtask

    task automatic inv(input string tag);
        chk({tag, "_pack"},
            {22'b0, RegDst, RegWrite, ALUOp, MemWrite,
             MemRead, MemtoReg, Branch, ALUSrc},
            {22'b0, ctrl_word});
        chk({tag, "_rdwr"}, {31'b0, MemRead & MemWrite}, 0);
        chk({tag, "_wr_rw"}, {31'b0, MemWrite & RegWrite}, 0);
        chk({tag, "_br"},
            {31'b0, Branch & (RegWrite | MemWrite)}, 0);
    endtask

    logic [5:0] ops [8];

    initial begin
        checks   = 0;
        errors   = 0;
        ops      = '{6'b000000, 6'b001000, 6'b001100, 6'b001101,
                     6'b001010, 6'b100011, 6'b101011, 6'b000100};
        rst_n    = 1'b0;
        opcode   = 6'b000000;
        op_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_word", {22'b0, ctrl_word}, 0);
        chk("rst_ill", {31'b0, illegal}, 0);
        chk("rst_regwr", {31'b0, RegWrite}, 0);

        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst_r", 6'b000000, 1'b1);

        step("seq_r",    6'b000000, 1'b1);
        step("seq_addi", 6'b001000, 1'b1);
        step("seq_lw",   6'b100011, 1'b1);
        step("seq_sw",   6'b101011, 1'b1);
        step("seq_beq",  6'b000100, 1'b1);

        step("andi", 6'b001100, 1'b1);
        chk("andi_aluop", {29'b0, ALUOp}, 3);
        step("ori", 6'b001101, 1'b1);
        chk("ori_aluop", {29'b0, ALUOp}, 4);
        step("slti", 6'b001010, 1'b1);
        chk("slti_aluop", {29'b0, ALUOp}, 5);
        chk("slti_alusrc", {31'b0, ALUSrc}, 1);

        step("ill_v1", 6'b111111, 1'b1);
        chk("ill_v1_flag", {31'b0, illegal}, 1);
        step("ill_v0", 6'b111111, 1'b0);
        chk("ill_v0_flag", {31'b0, illegal}, 0);
        step("bubble_lw", 6'b100011, 1'b0);

        step("lw_pre_rst", 6'b100011, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_memread", {31'b0, MemRead}, 0);
        chk("async_memtoreg", {31'b0, MemtoReg}, 0);
        chk("async_regwrite", {31'b0, RegWrite}, 0);
        @(posedge clk);
        #1;
        chk("rst_held_word", {22'b0, ctrl_word}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_async_lw", 6'b100011, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            logic [5:0] op;
            if ($urandom_range(0, 1) == 1)
                op = ops[$urandom_range(0, 7)];
            else
                op = 6'($urandom_range(0, 63));
            step("rand", op, ($urandom_range(0, 3) != 0));
            inv("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
